// File: rtl/risc16_pkg.sv
// Shared widths and types for the 16-bit RISC register file.
package risc16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [NUM_REGS-1:0] reg_array_t;

endpackage : risc16_pkg

// File: rtl/risc16_reg_file_if.sv
// Decode/writeback-facing bus of the register file; master drives selects and write data.
interface risc16_reg_file_if;
  import risc16_pkg::*;

  logic      I_en;
  logic      I_we;
  reg_addr_t I_selA;
  reg_addr_t I_selB;
  reg_addr_t I_selD;
  word_t     I_dataD;
  word_t     O_dataA;
  word_t     O_dataB;

  modport master (
    output I_en, I_we, I_selA, I_selB, I_selD, I_dataD,
    input  O_dataA, O_dataB
  );

  modport slave (
    input  I_en, I_we, I_selA, I_selB, I_selD, I_dataD,
    output O_dataA, O_dataB
  );

endinterface : risc16_reg_file_if

// File: rtl/risc16_rf_read_port.sv
// Registered 8:1 read mux; output updates only on enabled edges.
module risc16_rf_read_port
  import risc16_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  reg_addr_t  sel_i,
  input  reg_array_t regs_i,
  output word_t      data_o
);

  word_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = regs_i[sel_i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;

endmodule : risc16_rf_read_port

// File: rtl/risc16_reg_file.sv
// Eight-entry register file: two registered read ports, one write port, old-data on read-during-write.
module risc16_reg_file
  import risc16_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_rst_n,
  risc16_reg_file_if.slave  bus
);

  reg_array_t regs_q, regs_d;

  // Write decode; reads below see regs_q, so a same-edge read returns the old value.
  always_comb begin
    regs_d = regs_q;
    if (bus.I_en && bus.I_we) regs_d[bus.I_selD] = bus.I_dataD;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  risc16_rf_read_port u_port_a (
    .clk_i   (I_clk),
    .rst_n_i (I_rst_n),
    .en_i    (bus.I_en),
    .sel_i   (bus.I_selA),
    .regs_i  (regs_q),
    .data_o  (bus.O_dataA)
  );

  risc16_rf_read_port u_port_b (
    .clk_i   (I_clk),
    .rst_n_i (I_rst_n),
    .en_i    (bus.I_en),
    .sel_i   (bus.I_selB),
    .regs_i  (regs_q),
    .data_o  (bus.O_dataB)
  );

endmodule : risc16_reg_file

// File: tb/tb_risc16_reg_file.sv
// Directed bench for risc16_reg_file with hand-computed expectations.
module tb_risc16_reg_file;
  import risc16_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  risc16_reg_file_if bus ();

  risc16_reg_file dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 2 ns after the next rising edge: sample and drive point.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n       = 1'b0;
    bus.I_en    = 1'b0;
    bus.I_we    = 1'b0;
    bus.I_selA  = '0;
    bus.I_selB  = '0;
    bus.I_selD  = '0;
    bus.I_dataD = '0;
    #2;
    check("rst_a", bus.O_dataA, 16'h0000);
    check("rst_b", bus.O_dataB, 16'h0000);
    rst_n = 1'b1;
    tick();                                   // 7 ns

    // Basic write/read, old data on same edge
    bus.I_en = 1'b1; bus.I_we = 1'b1; bus.I_selD = 3'd0; bus.I_dataD = 16'hFFFF;
    bus.I_selA = 3'd0; bus.I_selB = 3'd1;
    tick();                                   // edge 15
    check("rdw_old_a", bus.O_dataA, 16'h0000);
    check("rdw_old_b", bus.O_dataB, 16'h0000);
    tick();                                   // edge 25
    check("r0_new_a", bus.O_dataA, 16'hFFFF);
    check("r0_new_b", bus.O_dataB, 16'h0000);

    // Write-enable gating and overwrite on r2
    bus.I_we = 1'b0; bus.I_selD = 3'd2; bus.I_dataD = 16'h2222; bus.I_selA = 3'd2;
    tick();
    tick();
    check("we0_r2", bus.O_dataA, 16'h0000);
    bus.I_we = 1'b1;
    tick();
    check("r2_wr_old", bus.O_dataA, 16'h0000);
    bus.I_dataD = 16'h3333;
    tick();
    check("r2_2222", bus.O_dataA, 16'h2222);
    bus.I_we = 1'b0;
    tick();
    check("r2_3333", bus.O_dataA, 16'h3333);

    // No write with we=0 over several edges
    bus.I_selD = 3'd0; bus.I_dataD = 16'hFEED; bus.I_selA = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("we0_r0", bus.O_dataA, 16'hFFFF);
    end

    // Dual read of the same register
    bus.I_we = 1'b1; bus.I_selD = 3'd4; bus.I_dataD = 16'h4444;
    tick();
    bus.I_we = 1'b0; bus.I_selA = 3'd4; bus.I_selB = 3'd4;
    tick();
    check("dual_a", bus.O_dataA, 16'h4444);
    check("dual_b", bus.O_dataB, 16'h4444);

    // Enable gating: no write, outputs hold
    bus.I_en = 1'b0; bus.I_we = 1'b1; bus.I_dataD = 16'h5555; bus.I_selA = 3'd0;
    tick();
    tick();
    check("en0_hold_a", bus.O_dataA, 16'h4444);
    check("en0_hold_b", bus.O_dataB, 16'h4444);
    bus.I_en = 1'b1; bus.I_we = 1'b0; bus.I_selA = 3'd4; bus.I_selB = 3'd0;
    tick();
    check("en0_r4", bus.O_dataA, 16'h4444);
    check("r0_via_b", bus.O_dataB, 16'hFFFF);

    // Top of the address range
    bus.I_we = 1'b1; bus.I_selD = 3'd7; bus.I_dataD = 16'hABCD;
    tick();
    bus.I_we = 1'b0; bus.I_selA = 3'd7; bus.I_selB = 3'd6;
    tick();
    check("r7_a", bus.O_dataA, 16'hABCD);
    check("r6_b", bus.O_dataB, 16'h0000);

    // Async reset mid-operation with nonzero outputs and a pending write
    bus.I_we = 1'b1; bus.I_selD = 3'd3; bus.I_dataD = 16'h7777;
    bus.I_selB = 3'd0;
    tick();
    check("pre_rst_b", bus.O_dataB, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", bus.O_dataA, 16'h0000);
    check("async_rst_b", bus.O_dataB, 16'h0000);
    tick();
    rst_n = 1'b1;
    bus.I_we = 1'b0;

    // Every register reads back zero after reset
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      bus.I_selA = reg_addr_t'(i);
      bus.I_selB = reg_addr_t'(NUM_REGS - 1 - i);
      tick();
      check($sformatf("clr_a_r%0d", i), bus.O_dataA, 16'h0000);
      check($sformatf("clr_b_r%0d", NUM_REGS - 1 - i), bus.O_dataB, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_risc16_reg_file
